// File: rtl/mux4a2_descp_condl1_if.sv
// Bus bundle for the L1 4-to-2 transmit mux: four input lanes in, two interleaved lanes out.
interface mux4a2_descp_condl1_if;
  logic       valid0, valid1, valid2, valid3;
  logic [7:0] data_in0_muxL1, data_in1_muxL1, data_in2_muxL1, data_in3_muxL1;
  logic       validout0, validout1;
  logic [7:0] dataout0_muxL1, dataout1_muxL1;

  modport master (
    output valid0, valid1, valid2, valid3,
    output data_in0_muxL1, data_in1_muxL1, data_in2_muxL1, data_in3_muxL1,
    input  validout0, validout1, dataout0_muxL1, dataout1_muxL1
  );

  modport slave (
    input  valid0, valid1, valid2, valid3,
    input  data_in0_muxL1, data_in1_muxL1, data_in2_muxL1, data_in3_muxL1,
    output validout0, validout1, dataout0_muxL1, dataout1_muxL1
  );
endinterface

// File: rtl/mux4a2_descp_condl1.sv
// L1 transmit mux: interleaves lanes 0/1 onto output 0 and lanes 2/3 onto output 1
// at twice the lane rate; counterpart of the L1 2-to-4 demux.

// One output lane: emits lane A on the even edge, and the lane B value captured
// on that same even edge one cycle later.
module mux4a2_descp_condl1_lane (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic       phase,
  input  logic       va,
  input  logic [7:0] da,
  input  logic       vb,
  input  logic [7:0] db,
  output logic       validout,
  output logic [7:0] dataout
);
  logic [7:0] hold;
  logic       hv;

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      hold     <= '0;
      hv       <= 1'b0;
      validout <= 1'b0;
      dataout  <= '0;
    end else if (!phase) begin
      validout <= va;
      if (va) dataout <= da;
      hold     <= db;
      hv       <= vb;
    end else begin
      // odd edge ignores live inputs; an invalid slot leaves the data bus parked
      validout <= hv;
      if (hv) dataout <= hold;
    end
  end
endmodule

module mux4a2_descp_condl1 (
  input  logic                 clk_2f,
  input  logic                 reset_L,
  mux4a2_descp_condl1_if.slave bus
);
  typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_t;

  phase_t state_q, state_d;

  logic [1:0]      va, vb, vout;
  logic [1:0][7:0] da, db, dout;

  always_ff @(posedge clk_2f) begin
    if (!reset_L) state_q <= PH_EVEN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_EVEN: state_d = PH_ODD;
      PH_ODD:  state_d = PH_EVEN;
      default: state_d = PH_EVEN;
    endcase
  end

  assign va = {bus.valid2, bus.valid0};
  assign vb = {bus.valid3, bus.valid1};
  assign da = {bus.data_in2_muxL1, bus.data_in0_muxL1};
  assign db = {bus.data_in3_muxL1, bus.data_in1_muxL1};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    mux4a2_descp_condl1_lane u_lane (
      .clk_2f   (clk_2f),
      .reset_L  (reset_L),
      .phase    (state_q == PH_ODD),
      .va       (va[g]),
      .da       (da[g]),
      .vb       (vb[g]),
      .db       (db[g]),
      .validout (vout[g]),
      .dataout  (dout[g])
    );
  end

  assign bus.validout0      = vout[0];
  assign bus.validout1      = vout[1];
  assign bus.dataout0_muxL1 = dout[0];
  assign bus.dataout1_muxL1 = dout[1];
endmodule

// File: tb/tb_mux4a2_descp_condl1.sv
// Scoreboard bench for the L1 4-to-2 mux: directed pairs with hand-computed outputs,
// mid-pair reset, and a streamed run rebuilt through a bench-side L1 demux.
module tb_mux4a2_descp_condl1;
  logic clk_2f = 1'b0;
  logic reset_L;

  mux4a2_descp_condl1_if bus();
  mux4a2_descp_condl1 dut (.clk_2f(clk_2f), .reset_L(reset_L), .bus(bus));

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    int         stamp;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] lb_q[$];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;
  int          lb_start = -1;
  exp_t        mon_e;
  logic [7:0]  r0, r2;
  logic [31:0] lb_want;

  always @(posedge clk_2f) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // monitor: compare the DUT against whatever entry is due this cycle
  always @(negedge clk_2f) begin
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      mon_e = sb.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missed_slot stamp=%0d cyc=%0d", mon_e.stamp, cyc);
    end
    if (sb.size() > 0 && sb[0].stamp == cyc) begin
      mon_e = sb.pop_front();
      chk("validout0", {31'd0, bus.validout0}, {31'd0, mon_e.v0});
      chk("dataout0",  {24'd0, bus.dataout0_muxL1}, {24'd0, mon_e.d0});
      chk("validout1", {31'd0, bus.validout1}, {31'd0, mon_e.v1});
      chk("dataout1",  {24'd0, bus.dataout1_muxL1}, {24'd0, mon_e.d1});
    end
  end

  // bench-side L1 demux: rebuild four lanes from two output slots and compare
  always @(negedge clk_2f) begin
    if (lb_start >= 0 && cyc >= lb_start && cyc < lb_start + 16) begin
      if (((cyc - lb_start) % 2) == 0) begin
        r0 = bus.dataout0_muxL1;
        r2 = bus.dataout1_muxL1;
      end else if (lb_q.size() > 0) begin
        lb_want = lb_q.pop_front();
        chk("loopback", {r0, bus.dataout0_muxL1, r2, bus.dataout1_muxL1}, lb_want);
      end else begin
        chk("loopback_underrun", 32'd1, 32'd0);
      end
    end
  end

  task automatic push(input int st, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    exp_t e;
    e.stamp = st; e.v0 = v0; e.d0 = d0; e.v1 = v1; e.d1 = d1;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [3:0] v,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    reset_L = rst;
    bus.valid0 = v[0]; bus.valid1 = v[1]; bus.valid2 = v[2]; bus.valid3 = v[3];
    bus.data_in0_muxL1 = d0; bus.data_in1_muxL1 = d1;
    bus.data_in2_muxL1 = d2; bus.data_in3_muxL1 = d3;
    @(negedge clk_2f);
  endtask

  task automatic drive_rand(input logic rst);
    drive(rst, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // one even/odd pair; junk replaces the odd-cycle inputs with 0xFF and flipped valids
  task automatic pair(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input bit junk,
                      input logic av0, input logic [7:0] ad0, input logic av1, input logic [7:0] ad1,
                      input logic bv0, input logic [7:0] bd0, input logic bv1, input logic [7:0] bd1);
    push(cyc + 1, av0, ad0, av1, ad1);
    push(cyc + 2, bv0, bd0, bv1, bd1);
    drive(1'b1, v, d0, d1, d2, d3);
    if (junk) drive(1'b1, ~v, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    else      drive(1'b1, v, d0, d1, d2, d3);
  endtask

  initial begin
    logic [7:0] s0, s1, s2, s3;

    // two reset edges with random inputs
    push(cyc + 1, 1'b0, 8'h00, 1'b0, 8'h00);
    push(cyc + 2, 1'b0, 8'h00, 1'b0, 8'h00);
    drive_rand(1'b0);
    drive_rand(1'b0);

    // first edge after release is an even edge
    pair(4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 8'h11, 1, 8'h33, 1, 8'h22, 1, 8'h44);
    pair(4'hF, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 0, 1, 8'hAA, 1, 8'hBB, 1, 8'hAA, 1, 8'hBB);
    // valid1 low: slot goes invalid, data parks on 0x5C
    pair(4'b1101, 8'h5C, 8'h77, 8'h66, 8'h99, 0, 1, 8'h5C, 1, 8'h66, 0, 8'h5C, 1, 8'h99);
    // odd-cycle inputs are ignored
    pair(4'hF, 8'h01, 8'h02, 8'h03, 8'h04, 1, 1, 8'h01, 1, 8'h03, 1, 8'h02, 1, 8'h04);
    // lanes 0 and 3 invalid, independent of their neighbours
    pair(4'b0110, 8'hEE, 8'h12, 8'h34, 8'hDD, 0, 0, 8'h02, 1, 8'h34, 1, 8'h12, 0, 8'h34);
    pair(4'h0, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 8'h12, 0, 8'h34, 0, 8'h12, 0, 8'h34);

    // reset lands on the odd edge: held 0x22/0x44 must never appear
    push(cyc + 1, 1'b1, 8'h11, 1'b1, 8'h33);
    drive(1'b1, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
    push(cyc + 1, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
    push(cyc + 1, 1'b0, 8'h00, 1'b0, 8'h00);
    drive_rand(1'b0);

    // back-to-back stream, also rebuilt through the bench demux
    lb_start = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      s0 = 8'(8'h40 + 4 * i); s1 = 8'(s0 + 8'd1); s2 = 8'(s0 + 8'd2); s3 = 8'(s0 + 8'd3);
      lb_q.push_back({s0, s1, s2, s3});
      pair(4'hF, s0, s1, s2, s3, 0, 1, s0, 1, s2, 1, s1, 1, s3);
    end

    for (int i = 0; i < 4; i++) drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("sb_drained", sb.size(), 32'd0);
    chk("lb_drained", lb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
